// File: rtl/relu_pre_accumulator.sv
// relu_pre_accumulator
// Sums signed per-element products over a vector of vector_len beats and
// emits one saturated DATA_WIDTH sum per vector as a single-cycle pulse
// toward the ReLU stage. The stream has no backpressure.
module relu_pre_accumulator #(
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH  = 32,
  parameter int LEN_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] product_tdata,
  input  logic                  product_tvalid,
  input  logic [LEN_WIDTH-1:0]  vector_len,
  output logic [DATA_WIDTH-1:0] pre_relu_tdata,
  output logic                  pre_relu_tvalid,
  output logic                  busy,
  output logic                  sat_pulse,
  output logic                  sat_sticky
);

  // Clip limits expressed at accumulator width so the compare is exact.
  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
    {{(ACC_WIDTH-DATA_WIDTH+1){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
    {{(ACC_WIDTH-DATA_WIDTH+1){1'b1}}, {(DATA_WIDTH-1){1'b0}}};
  localparam logic [DATA_WIDTH-1:0] OUT_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] OUT_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam logic [LEN_WIDTH-1:0]  LEN_ONE = LEN_WIDTH'(1);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_t;

  state_t                        state_q, state_d;
  logic signed [ACC_WIDTH-1:0]   acc_q, acc_d;
  logic [LEN_WIDTH-1:0]          cnt_q, cnt_d;
  logic [LEN_WIDTH-1:0]          len_q, len_d;
  logic [DATA_WIDTH-1:0]         tdata_q, tdata_d;
  logic                          tvalid_q, tvalid_d;
  logic                          sat_pulse_q, sat_pulse_d;
  logic                          sat_sticky_q, sat_sticky_d;

  logic signed [ACC_WIDTH-1:0]   prod_ext;
  logic signed [ACC_WIDTH-1:0]   sum;
  logic [LEN_WIDTH-1:0]          len_eff;
  logic                          emit;
  logic                          clip_hi;
  logic                          clip_lo;

  // A zero length would never complete, so it behaves as a one-beat vector.
  assign len_eff  = (vector_len == '0) ? LEN_ONE : vector_len;
  assign prod_ext = {{(ACC_WIDTH-DATA_WIDTH){product_tdata[DATA_WIDTH-1]}}, product_tdata};

  // Next-state: vector sequencing, accumulation and emit decision.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    len_d   = len_q;
    sum     = acc_q + prod_ext;
    emit    = 1'b0;
    case (state_q)
      IDLE: begin
        if (product_tvalid) begin
          len_d = len_eff;
          sum   = prod_ext;
          acc_d = prod_ext;
          cnt_d = LEN_ONE;
          if (len_eff == LEN_ONE) begin
            emit = 1'b1;
          end else begin
            state_d = ACCUM;
          end
        end
      end
      ACCUM: begin
        if (product_tvalid) begin
          sum   = acc_q + prod_ext;
          acc_d = sum;
          cnt_d = cnt_q + LEN_ONE;
          // Length was latched on the first beat; mid-vector changes are ignored.
          if (cnt_d == len_q) begin
            emit    = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Output stage: saturate the completed sum; outputs idle at zero otherwise.
  always_comb begin
    clip_hi      = (sum > SAT_MAX);
    clip_lo      = (sum < SAT_MIN);
    tvalid_d     = emit;
    tdata_d      = '0;
    sat_pulse_d  = 1'b0;
    sat_sticky_d = sat_sticky_q;
    if (emit) begin
      if (clip_hi) begin
        tdata_d = OUT_MAX;
      end else if (clip_lo) begin
        tdata_d = OUT_MIN;
      end else begin
        tdata_d = sum[DATA_WIDTH-1:0];
      end
      sat_pulse_d  = clip_hi | clip_lo;
      sat_sticky_d = sat_sticky_q | clip_hi | clip_lo;
    end
  end

  // State and output registers; reset discards any partial vector.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      acc_q        <= '0;
      cnt_q        <= '0;
      len_q        <= '0;
      tdata_q      <= '0;
      tvalid_q     <= 1'b0;
      sat_pulse_q  <= 1'b0;
      sat_sticky_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      len_q        <= len_d;
      tdata_q      <= tdata_d;
      tvalid_q     <= tvalid_d;
      sat_pulse_q  <= sat_pulse_d;
      sat_sticky_q <= sat_sticky_d;
    end
  end

  assign pre_relu_tdata  = tdata_q;
  assign pre_relu_tvalid = tvalid_q;
  assign busy            = (state_q == ACCUM);
  assign sat_pulse       = sat_pulse_q;
  assign sat_sticky      = sat_sticky_q;

endmodule

// File: tb/tb_relu_pre_accumulator.sv
// Directed bench for relu_pre_accumulator. Inputs change on the falling
// edge; outputs are checked on the falling edge after the rising edge that
// consumed the beat of interest.
module tb_relu_pre_accumulator;

  logic        clk;
  logic        rst;
  logic [15:0] product_tdata;
  logic        product_tvalid;
  logic [15:0] vector_len;
  logic [15:0] pre_relu_tdata;
  logic        pre_relu_tvalid;
  logic        busy;
  logic        sat_pulse;
  logic        sat_sticky;

  int n_vec;
  int n_err;

  relu_pre_accumulator dut (
    .clk            (clk),
    .rst            (rst),
    .product_tdata  (product_tdata),
    .product_tvalid (product_tvalid),
    .vector_len     (vector_len),
    .pre_relu_tdata (pre_relu_tdata),
    .pre_relu_tvalid(pre_relu_tvalid),
    .busy           (busy),
    .sat_pulse      (sat_pulse),
    .sat_sticky     (sat_sticky)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hard bound on run time.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  // Present one cycle of stimulus starting at the falling edge.
  task automatic tick(input logic v, input int d, input int len);
    @(negedge clk);
    product_tvalid = v;
    product_tdata  = 16'(d);
    vector_len     = 16'(len);
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [15:0] d);
    chk({tag, "_tvalid"}, {31'd0, pre_relu_tvalid}, {31'd0, v});
    chk({tag, "_tdata"},  {16'd0, pre_relu_tdata}, {16'd0, d});
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    rst = 1'b1;
    product_tvalid = 1'b0;
    product_tdata  = '0;
    vector_len     = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Reset state
    chk_out("rst", 1'b0, 16'h0000);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_satp", {31'd0, sat_pulse}, 32'd0);
    chk("rst_sticky", {31'd0, sat_sticky}, 32'd0);

    // len 4: 100, -50, 200, 25 -> 275
    tick(1, 100, 4);
    tick(1, -50, 4);  chk("v1_busy1", {31'd0, busy}, 32'd1);
    tick(1, 200, 4);  chk("v1_busy2", {31'd0, busy}, 32'd1);
    tick(1, 25, 4);   chk("v1_busy3", {31'd0, busy}, 32'd1); chk_out("v1_mid", 1'b0, 16'h0);
    tick(0, 0, 4);    chk_out("v1_sum", 1'b1, 16'd275); chk("v1_busy_end", {31'd0, busy}, 32'd0);
    tick(0, 0, 4);    chk_out("v1_after", 1'b0, 16'h0);

    // len 3 with gaps: 1000, gap5, 2000, gap2, -500 -> 2500
    tick(1, 1000, 3);
    for (int i = 0; i < 5; i++) tick(0, 0, 3);
    chk("v2_gap_busy", {31'd0, busy}, 32'd1);
    chk_out("v2_gap", 1'b0, 16'h0);
    tick(1, 2000, 3);
    tick(0, 0, 3);
    tick(0, 0, 3);    chk("v2_gap2_busy", {31'd0, busy}, 32'd1);
    tick(1, -500, 3);
    tick(0, 0, 3);    chk_out("v2_sum", 1'b1, 16'd2500);

    // len 2 saturation both ways
    tick(1, 30000, 2);
    tick(1, 30000, 2);
    tick(1, -30000, 2); chk_out("v3_pos", 1'b1, 16'h7FFF); chk("v3_satp_pos", {31'd0, sat_pulse}, 32'd1);
    tick(1, -30000, 2); chk_out("v3_gap", 1'b0, 16'h0);
    tick(0, 0, 2);    chk_out("v3_neg", 1'b1, 16'h8000); chk("v3_satp_neg", {31'd0, sat_pulse}, 32'd1);
    tick(0, 0, 2);    chk("v3_satp_off", {31'd0, sat_pulse}, 32'd0); chk("v3_sticky", {31'd0, sat_sticky}, 32'd1);

    // len 1: 5, -7, 9, then len 0 with 3
    tick(1, 5, 1);
    tick(1, -7, 1);   chk_out("v4_a", 1'b1, 16'd5); chk("v4_busy_a", {31'd0, busy}, 32'd0);
    tick(1, 9, 1);    chk_out("v4_b", 1'b1, 16'hFFF9); chk("v4_satp", {31'd0, sat_pulse}, 32'd0);
    tick(1, 3, 0);    chk_out("v4_c", 1'b1, 16'd9);
    tick(0, 0, 0);    chk_out("v4_len0", 1'b1, 16'd3); chk("v4_busy_d", {31'd0, busy}, 32'd0);

    // Back-to-back len 2: 1,2,3,4 -> 3,7; len change to 5 on second beat ignored
    tick(1, 1, 2);
    tick(1, 2, 5);    chk("v5_busy", {31'd0, busy}, 32'd1);
    tick(1, 3, 2);    chk_out("v5_a", 1'b1, 16'd3);
    tick(1, 4, 2);    chk_out("v5_mid", 1'b0, 16'h0); chk("v5_busy2", {31'd0, busy}, 32'd1);
    tick(0, 0, 2);    chk_out("v5_b", 1'b1, 16'd7);

    // Asynchronous reset mid-vector
    tick(1, 10, 4);
    tick(1, 20, 4);
    tick(0, 0, 4);    chk("v6_busy_pre", {31'd0, busy}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("v6_rst_busy", {31'd0, busy}, 32'd0);
    chk("v6_rst_sticky", {31'd0, sat_sticky}, 32'd0);
    chk_out("v6_rst", 1'b0, 16'h0);
    @(negedge clk);
    rst = 1'b0;
    tick(1, 1, 4);
    tick(1, 1, 4);
    tick(1, 1, 4);
    tick(1, 1, 4);
    tick(0, 0, 4);    chk_out("v6_sum", 1'b1, 16'd4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/relu_pre_accumulator.md
Name: relu_pre_accumulator

Overview:
- Producer end of the pre-ReLU stream: drives pre_relu_tdata/pre_relu_tvalid into the ReLU stage.
- Accumulates signed per-element products from the photonic multiply readout over a vector of vector_len beats. Emits one saturated signed DATA_WIDTH sum per vector as a single-cycle valid pulse.
- Stream has no backpressure, matching the ReLU consumer.

Parameters:
- DATA_WIDTH, 16, width of input products and output sum (two's complement).
- ACC_WIDTH, 32, internal accumulator width. Must be >= DATA_WIDTH + LEN_WIDTH so the accumulator cannot overflow internally.
- LEN_WIDTH, 16, width of the vector length input.

Ports:
- clk, input, 1, system clock.
- rst, input, 1, asynchronous active-high reset.
- product_tdata, input, DATA_WIDTH, signed element product.
- product_tvalid, input, 1, product_tdata valid this cycle.
- vector_len, input, LEN_WIDTH, beats per vector. Sampled on the first beat of each vector; 0 is treated as 1.
- pre_relu_tdata, output, DATA_WIDTH, saturated signed vector sum.
- pre_relu_tvalid, output, 1, one-cycle pulse per completed vector.
- busy, output, 1, high while a vector is partially accumulated.
- sat_pulse, output, 1, one-cycle pulse coincident with a pre_relu_tvalid whose sum was clipped.
- sat_sticky, output, 1, set on any clip; cleared only by rst.

Behaviour:
- Reset: clk and rst as stated; rst is asynchronous and active-high.
  - Asserting rst immediately clears: state to IDLE, accumulator, beat counter, latched length, pre_relu_tdata (0), pre_relu_tvalid (0), busy (0), sat_pulse (0), sat_sticky (0).
  - A partial vector in progress is discarded. The first beat after release starts a fresh vector.
- IDLE state:
  - On product_tvalid:
    - Latch len = max(vector_len, 1).
    - acc <= sign-extend(product_tdata).
    - cnt <= 1.
  - If len == 1: emit (see Emit below) and stay in IDLE. Otherwise go to ACCUM.
- ACCUM state:
  - On product_tvalid: acc <= acc + sign-extend(product_tdata); cnt <= cnt + 1.
  - If cnt + 1 == len, this is the last beat: emit and go to IDLE.
  - Cycles with product_tvalid low hold all state; gaps of any length are allowed.
- Emit (registered):
  - s = acc + sign-extend(last beat), i.e. the full sum including the final beat.
  - Next cycle:
    - pre_relu_tvalid = 1.
    - pre_relu_tdata = sat(s): s > 2^(DATA_WIDTH-1)-1 gives 0x7FFF; s < -2^(DATA_WIDTH-1) gives 0x8000; otherwise the low DATA_WIDTH bits.
    - sat_pulse = 1 if clipped; sat_sticky is set if clipped.
  - In every cycle without an emit, pre_relu_tvalid = 0, pre_relu_tdata = 0 and sat_pulse = 0.
- Latency: pre_relu_tvalid asserts exactly 1 cycle after the last beat of a vector.
- Back-to-back vectors: a beat arriving in the cycle pre_relu_tvalid is high is the first beat of the next vector. No bubbles; sustained throughput is 1 beat per cycle.
- busy = (state == ACCUM).
- vector_len changes mid-vector are ignored until the next first beat.
- Maximum length 2^LEN_WIDTH - 1 cannot overflow ACC_WIDTH with the default parameters.

Test Plan:
- Reset then vector_len=4, products 100, -50, 200, 25 on consecutive cycles -> pre_relu_tvalid pulse one cycle after 25 with tdata=275; busy high for cycles 1-3 of the vector.
- vector_len=3, products 1000, gap of 5 invalid cycles, 2000, gap of 2, -500 -> single output 2500; busy held through the gaps.
- vector_len=2, continuous stream 30000, 30000, then -30000, -30000 -> outputs 0x7FFF then 0x8000 on consecutive emits, sat_pulse on both, sat_sticky=1 until rst.
- vector_len=1, products 5, -7, 9 on three consecutive cycles -> three consecutive output cycles with 5, 0xFFF9, 9; busy never asserts. Then vector_len=0 with product 3 -> output 3.
- Back-to-back with vector_len=2: stream 1, 2, 3, 4 -> outputs 3 and 7 with no bubble between vectors; change vector_len to 5 during the second beat -> no effect on that vector.
- vector_len=4, after 2 beats (10, 20) assert rst asynchronously mid-cycle -> all outputs 0 immediately; after release a new vector 1, 1, 1, 1 -> output 4, with no residue of 30.
